alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle sequencer and arbiter in front of the shared single-pass ALU (ADD/SUB, 1-bit shifter, logic unit). Accepts operation commands from two requesters over valid/ready, grants one at a time by round-robin, and drives the ALU's 3-bit OP and operands. Shift commands with amount > 1 are executed by iterating the 1-bit shifter and feeding the result back. One response per command is returned with the originating requester ID.

## Interface
- W, 32, datapath width
- SHW, 5, shift-amount width (clog2(W))
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- REQ_VALID  in  2  per-requester command valid (bit i = requester i)
- REQ_READY  out  2  per-requester accept
- REQ_OP  in  6  {op1, op0}, 3 bits each
- REQ_A  in  2W  {a1, a0}
- REQ_B  in  2W  {b1, b0}
- REQ_SHAMT  in  2*SHW  {s1, s0}, used for shift-class ops only
- ALU_OP  out  3  opcode to ALU
- ALU_A, ALU_B  out  W  ALU operands
- ALU_R  in  W  ALU result, combinational from ALU_OP/ALU_A/ALU_B
- RSP_VALID  out  1  result valid
- RSP_READY  in  1  consumer accept
- RSP_DATA  out  W  result
- RSP_ID  out  1  requester index of result
- BUSY  out  1  high in any state but IDLE

## Operation
- Opcode classes: ADD 000, SUB 001; SHIFT class {010, 011, 100, 111}; LOGIC class {101, 110}.
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE:
  - Grant g is taken from the valid requesters by round-robin. The requester not granted last wins a tie. After reset, requester 0 wins.
  - REQ_READY[g] = 1 combinationally. The other bit is 0. Both bits are 0 when no request is valid.
  - On handshake: capture op, a, b, shamt into op_r, a_r, b_r, cnt_r; set id_r = g; update the RR pointer; go to EXEC.
- EXEC:
  - ALU_OP = op_r, ALU_A = a_r, ALU_B = b_r.
  - SHIFT class with cnt_r > 1: a_r <= ALU_R, cnt_r <= cnt_r - 1, stay in EXEC.
  - SHIFT class with cnt_r == 0: res_r <= a_r (ALU result ignored), go to DONE.
  - All other cases: res_r <= ALU_R, go to DONE.
- DONE:
  - RSP_VALID = 1, RSP_DATA = res_r, RSP_ID = id_r, all held stable.
  - On RSP_READY go to IDLE.
- Outside EXEC: ALU_OP = 000 and ALU_A = ALU_B = 0.
- Commands are never reordered or merged. Exactly one response per accepted command.

## Timing
- Reset (RST high at an edge): next cycle state = IDLE, RR pointer favours requester 0. REQ_READY, RSP_VALID, BUSY, ALU_* outputs are all 0.
- Reset mid-EXEC or mid-DONE aborts the command and drops its response.
- Handshake in cycle t → EXEC occupies cycles t+1 … t+N → RSP_VALID first high in cycle t+N+1.
  - N = shamt for SHIFT class with shamt ≥ 1.
  - N = 1 for everything else, including shamt = 0.
- Back-pressure: DONE holds indefinitely while RSP_READY = 0. REQ_READY stays 0 meanwhile.
- Minimum command spacing is N+2 cycles (IDLE, EXEC×N, DONE).
- cnt_r never wraps. Maximum shamt = 2^SHW − 1 gives N = 31.
- Requests arriving during BUSY are not accepted. Requesters hold REQ_VALID and their command stable until REQ_READY.

## Structure
- Package `alu_seq_pkg`:
  - opcode localparams (OP_ADD, OP_SUB, shift and logic codes)
  - state enum {IDLE, EXEC, DONE}
  - function `is_shift(op)`
- Sub-module `rr_arbiter2`:
  - inputs: 2-bit request vector, advance strobe
  - output: one-hot grant
  - internal: last-grant flop, reset to favour requester 0
- Top level: FSM, operand/count/result registers, ALU mux.
- The ALU and its opcode decoder stay outside this block.

## Test plan
- Single ADD: req0 op=000, A=5, B=7 → ALU_OP=000 for 1 cycle; RSP_DATA=12, RSP_ID=0, RSP_VALID at t+2.
- Iterated shift: req1 op=010, A=0x1, shamt=4, with the ALU model doing a 1-bit left shift → 4 EXEC cycles, ALU_A sequence 1, 2, 4, 8; RSP_DATA=0x10, RSP_ID=1 at t+5.
- shamt=0 shift: op=011, A=0xA5 → RSP_DATA=0xA5 after 1 EXEC cycle.
- Contention: both REQ_VALID held high for 4 commands → grants alternate 0, 1, 0, 1; first grant is 0 after reset.
- Back-pressure: RSP_READY low for 10 cycles in DONE → RSP_DATA/RSP_ID stable, REQ_READY=0 throughout, next grant only after release.
- Reset mid-shift: RST in the 2nd of 6 EXEC cycles → no response, IDLE next cycle, next contended grant goes to requester 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcode codes, FSM state type and
// the shift-class decode used by the sequencer.
package alu_seq_pkg;

   localparam logic [2:0] OP_ADD    = 3'b000;
   localparam logic [2:0] OP_SUB    = 3'b001;
   localparam logic [2:0] OP_SHIFT0 = 3'b010;
   localparam logic [2:0] OP_SHIFT1 = 3'b011;
   localparam logic [2:0] OP_SHIFT2 = 3'b100;
   localparam logic [2:0] OP_LOGIC0 = 3'b101;
   localparam logic [2:0] OP_LOGIC1 = 3'b110;
   localparam logic [2:0] OP_SHIFT3 = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic is_shift(input logic [2:0] op);
      return op inside {OP_SHIFT0, OP_SHIFT1, OP_SHIFT2, OP_SHIFT3};
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   req_i     : request vector, bit i = requester i
//   advance_i : grant consumed this cycle, rotate priority
//   gnt_o     : one-hot grant (zero when no request)
module rr_arbiter2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] gnt_o
);

   // Index of the requester granted last; reset to 1 so requester 0 wins first.
   logic last_q;
   logic last_d;

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
      last_d = (advance_i && (gnt_o != 2'b00)) ? gnt_o[1] : last_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer/arbiter in front of a shared single-pass ALU. Two requesters
// issue commands over valid/ready; one is granted at a time (round-robin),
// its operands are driven to the ALU, multi-bit shifts are iterated through
// the 1-bit shifter, and one response is returned with the requester ID.
//   CLK, RST        : clock, synchronous active-high reset
//   REQ_VALID/READY : per-requester command handshake
//   REQ_OP/A/B/SHAMT: packed per-requester command fields {r1, r0}
//   ALU_OP/A/B      : ALU drive (zero outside EXEC)
//   ALU_R           : combinational ALU result
//   RSP_VALID/READY : response handshake, RSP_DATA/RSP_ID held in DONE
//   BUSY            : any state but IDLE
//
// state | meaning
// IDLE  | waiting for a command, arbiter grant visible on REQ_READY
// EXEC  | ALU driven from captured operands, one cycle per shift step
// DONE  | response presented until RSP_READY
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int W   = 32,
   parameter int SHW = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [1:0]       REQ_VALID,
   output logic [1:0]       REQ_READY,
   input  logic [5:0]       REQ_OP,
   input  logic [2*W-1:0]   REQ_A,
   input  logic [2*W-1:0]   REQ_B,
   input  logic [2*SHW-1:0] REQ_SHAMT,
   output logic [2:0]       ALU_OP,
   output logic [W-1:0]     ALU_A,
   output logic [W-1:0]     ALU_B,
   input  logic [W-1:0]     ALU_R,
   output logic             RSP_VALID,
   input  logic             RSP_READY,
   output logic [W-1:0]     RSP_DATA,
   output logic             RSP_ID,
   output logic             BUSY
);

   localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

   state_e         state_q;
   logic [2:0]     op_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   res_q;
   logic [SHW-1:0] cnt_q;
   logic           id_q;

   logic [1:0]     gnt;
   logic           gnt_idx;
   logic           hs;
   logic           in_exec;

   logic [2:0]     op_sel;
   logic [W-1:0]   a_sel;
   logic [W-1:0]   b_sel;
   logic [SHW-1:0] sh_sel;

   rr_arbiter2 u_arb (
      .clk_i     (CLK),
      .rst_i     (RST),
      .req_i     (REQ_VALID),
      .advance_i (hs),
      .gnt_o     (gnt)
   );

   // Grant is only exposed in IDLE and never during a reset cycle, so no
   // command can be accepted that the reset would then silently drop.
   assign REQ_READY = ((state_q == IDLE) && !RST) ? gnt : 2'b00;
   assign hs        = |(REQ_READY & REQ_VALID);
   assign gnt_idx   = gnt[1];

   assign op_sel = gnt_idx ? REQ_OP[5:3]             : REQ_OP[2:0];
   assign a_sel  = gnt_idx ? REQ_A[2*W-1:W]          : REQ_A[W-1:0];
   assign b_sel  = gnt_idx ? REQ_B[2*W-1:W]          : REQ_B[W-1:0];
   assign sh_sel = gnt_idx ? REQ_SHAMT[2*SHW-1:SHW]  : REQ_SHAMT[SHW-1:0];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         op_q    <= OP_ADD;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         id_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hs) begin
                  op_q    <= op_sel;
                  a_q     <= a_sel;
                  b_q     <= b_sel;
                  cnt_q   <= sh_sel;
                  id_q    <= gnt_idx;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (is_shift(op_q) && (cnt_q > CNT_ONE)) begin
                  // Feed the 1-bit shift back; the last step (cnt 1) takes the
                  // normal exit below so N equals the shift amount.
                  a_q   <= ALU_R;
                  cnt_q <= cnt_q - CNT_ONE;
               end else begin
                  // A zero-amount shift returns the operand untouched.
                  res_q   <= (is_shift(op_q) && (cnt_q == '0)) ? a_q : ALU_R;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (RSP_READY) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_exec   = (state_q == EXEC);
   assign ALU_OP    = in_exec ? op_q : OP_ADD;
   assign ALU_A     = in_exec ? a_q  : '0;
   assign ALU_B     = in_exec ? b_q  : '0;
   assign RSP_VALID = (state_q == DONE);
   assign RSP_DATA  = res_q;
   assign RSP_ID    = id_q;
   assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

   localparam int W   = 32;
   localparam int SHW = 5;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
   } cmd_t;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          n;
      int          due;
   } exp_t;

   logic          CLK = 1'b0;
   logic          RST;
   logic [1:0]    REQ_VALID;
   logic [1:0]    REQ_READY;
   logic [5:0]    REQ_OP;
   logic [63:0]   REQ_A;
   logic [63:0]   REQ_B;
   logic [9:0]    REQ_SHAMT;
   logic [2:0]    ALU_OP;
   logic [31:0]   ALU_A;
   logic [31:0]   ALU_B;
   logic [31:0]   ALU_R;
   logic          RSP_VALID;
   logic          RSP_READY;
   logic [31:0]   RSP_DATA;
   logic          RSP_ID;
   logic          BUSY;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   hs_count = 0;
   int   hs_cyc = 0;

   cmd_t cmdq0[$];
   cmd_t cmdq1[$];
   exp_t exp_order[$];
   exp_t sb[$];

   alu_sequencer #(.W(W), .SHW(SHW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .REQ_VALID (REQ_VALID),
      .REQ_READY (REQ_READY),
      .REQ_OP    (REQ_OP),
      .REQ_A     (REQ_A),
      .REQ_B     (REQ_B),
      .REQ_SHAMT (REQ_SHAMT),
      .ALU_OP    (ALU_OP),
      .ALU_A     (ALU_A),
      .ALU_B     (ALU_B),
      .ALU_R     (ALU_R),
      .RSP_VALID (RSP_VALID),
      .RSP_READY (RSP_READY),
      .RSP_DATA  (RSP_DATA),
      .RSP_ID    (RSP_ID),
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Reference ALU: single pass, 1-bit shifter.
   always_comb begin
      ALU_R = 32'h0;
      case (ALU_OP)
         3'b000: ALU_R = ALU_A + ALU_B;
         3'b001: ALU_R = ALU_A - ALU_B;
         3'b010: ALU_R = ALU_A << 1;
         3'b011: ALU_R = ALU_A >> 1;
         3'b100: ALU_R = {ALU_A[31], ALU_A[31:1]};
         3'b101: ALU_R = ALU_A & ALU_B;
         3'b110: ALU_R = ALU_A | ALU_B;
         3'b111: ALU_R = {ALU_A[30:0], ALU_A[31]};
         default: ALU_R = 32'h0;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name, input string msg);
      n_vec++;
      n_err++;
      $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
   endtask

   task automatic issue(input int r, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] res, input int n);
      cmd_t c;
      exp_t e;
      c.op = op; c.a = a; c.b = b; c.sh = sh;
      e.id = r; e.data = res; e.n = n; e.due = 0;
      if (r == 0) cmdq0.push_back(c);
      else        cmdq1.push_back(c);
      exp_order.push_back(e);
   endtask

   task automatic on_handshake(input int r);
      exp_t e;
      hs_count++;
      hs_cyc = cyc;
      if (exp_order.size() == 0) begin
         fail("unexpected_grant", $sformatf("requester %0d granted, none expected", r));
      end else begin
         e = exp_order.pop_front();
         chk("grant_id", 64'(r), 64'(e.id));
         e.due = cyc + e.n + 1;
         sb.push_back(e);
      end
   endtask

   // Driver: presents the head of each requester's queue, pops on handshake.
   initial begin
      logic hs0, hs1;
      REQ_VALID = 2'b00;
      REQ_OP    = '0;
      REQ_A     = '0;
      REQ_B     = '0;
      REQ_SHAMT = '0;
      forever begin
         @(negedge CLK);
         hs0 = 1'b0;
         hs1 = 1'b0;
         if (!RST) begin
            if (REQ_VALID[0] && REQ_READY[0]) begin hs0 = 1'b1; on_handshake(0); end
            if (REQ_VALID[1] && REQ_READY[1]) begin hs1 = 1'b1; on_handshake(1); end
         end
         @(posedge CLK);
         #1;
         if (hs0 && cmdq0.size() > 0) cmdq0.delete(0);
         if (hs1 && cmdq1.size() > 0) cmdq1.delete(0);
         if (cmdq0.size() > 0) begin
            REQ_VALID[0]    = 1'b1;
            REQ_OP[2:0]     = cmdq0[0].op;
            REQ_A[31:0]     = cmdq0[0].a;
            REQ_B[31:0]     = cmdq0[0].b;
            REQ_SHAMT[4:0]  = cmdq0[0].sh;
         end else begin
            REQ_VALID[0]    = 1'b0;
         end
         if (cmdq1.size() > 0) begin
            REQ_VALID[1]    = 1'b1;
            REQ_OP[5:3]     = cmdq1[0].op;
            REQ_A[63:32]    = cmdq1[0].a;
            REQ_B[63:32]    = cmdq1[0].b;
            REQ_SHAMT[9:5]  = cmdq1[0].sh;
         end else begin
            REQ_VALID[1]    = 1'b0;
         end
      end
   end

   // Monitor: compares every presented response against the scoreboard head.
   initial begin
      logic in_rsp;
      in_rsp = 1'b0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            in_rsp = 1'b0;
         end else if (RSP_VALID) begin
            if (sb.size() == 0) begin
               fail("unexpected_rsp", $sformatf("data %0h id %0d, none expected", RSP_DATA, RSP_ID));
            end else begin
               if (!in_rsp) begin
                  chk("rsp_latency", 64'(cyc), 64'(sb[0].due));
                  chk("rsp_id", 64'(RSP_ID), 64'(sb[0].id));
                  in_rsp = 1'b1;
               end
               chk("rsp_data", 64'(RSP_DATA), 64'(sb[0].data));
               if (RSP_READY) begin
                  sb.delete(0);
                  in_rsp = 1'b0;
               end
            end
         end
      end
   end

   task automatic wait_hs(input int start);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(posedge CLK);
         if (hs_count != start) seen = 1'b1;
      end
      if (!seen) fail("hs_timeout", "no handshake within 200 cycles");
   endtask

   task automatic wait_drain();
      logic done;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(posedge CLK);
         if (cmdq0.size() == 0 && cmdq1.size() == 0 && exp_order.size() == 0 && sb.size() == 0)
            done = 1'b1;
      end
      if (!done) fail("drain_timeout", $sformatf("%0d responses outstanding", sb.size() + exp_order.size()));
   endtask

   task automatic do_reset();
      @(posedge CLK);
      #1;
      RST = 1'b1;
      sb.delete();
      exp_order.delete();
      cmdq0.delete();
      cmdq1.delete();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      int rel_cyc;
      logic got;
      RST       = 1'b1;
      RSP_READY = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;

      // Reset state
      @(negedge CLK);
      chk("rst_req_ready", 64'(REQ_READY), 64'(0));
      chk("rst_rsp_valid", 64'(RSP_VALID), 64'(0));
      chk("rst_busy", 64'(BUSY), 64'(0));
      chk("rst_alu_op", 64'(ALU_OP), 64'(0));
      chk("rst_alu_a", 64'(ALU_A), 64'(0));
      chk("rst_alu_b", 64'(ALU_B), 64'(0));

      // Single ADD: 5 + 7
      start = hs_count;
      issue(0, 3'b000, 32'd5, 32'd7, 5'd0, 32'd12, 1);
      wait_hs(start);
      @(negedge CLK);
      chk("add_exec_op", 64'(ALU_OP), 64'(3'b000));
      chk("add_exec_a", 64'(ALU_A), 64'(5));
      chk("add_exec_b", 64'(ALU_B), 64'(7));
      chk("add_busy", 64'(BUSY), 64'(1));
      @(negedge CLK);
      chk("add_done_alu_a", 64'(ALU_A), 64'(0));
      wait_drain();

      // Iterated left shift by 4 from requester 1
      start = hs_count;
      issue(1, 3'b010, 32'h1, 32'h0, 5'd4, 32'h10, 4);
      wait_hs(start);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         chk($sformatf("shl_step%0d_a", k), 64'(ALU_A), 64'(32'h1 << k));
         chk($sformatf("shl_step%0d_op", k), 64'(ALU_OP), 64'(3'b010));
      end
      wait_drain();

      // Directed single-command vectors
      issue(0, 3'b011, 32'hA5, 32'h0, 5'd0, 32'hA5, 1);              // shamt 0 passes A
      wait_drain();
      issue(1, 3'b011, 32'hA5, 32'h0, 5'd1, 32'h52, 1);              // shamt 1 single step
      wait_drain();
      issue(0, 3'b001, 32'd10, 32'd3, 5'd0, 32'd7, 1);               // SUB
      wait_drain();
      issue(1, 3'b101, 32'hF0F0, 32'hFF00, 5'd9, 32'hF000, 1);       // AND ignores shamt
      wait_drain();
      issue(0, 3'b000, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'h0, 1);        // ADD wraps, shamt ignored
      wait_drain();
      issue(1, 3'b100, 32'h8000_0000, 32'h0, 5'd3, 32'hF000_0000, 3); // arithmetic right
      wait_drain();
      issue(0, 3'b111, 32'h8000_0001, 32'h0, 5'd2, 32'h0000_0006, 2); // rotate
      wait_drain();
      issue(1, 3'b010, 32'h1, 32'h0, 5'd31, 32'h8000_0000, 31);      // maximum shamt
      wait_drain();

      // Contention: both requesters held valid, grants alternate from 0
      do_reset();
      issue(0, 3'b000, 32'd1, 32'd1, 5'd0, 32'd2, 1);
      issue(1, 3'b001, 32'd9, 32'd1, 5'd0, 32'd8, 1);
      issue(0, 3'b000, 32'd2, 32'd2, 5'd0, 32'd4, 1);
      issue(1, 3'b110, 32'h30, 32'h03, 5'd5, 32'h33, 1);
      wait_drain();

      // Back-pressure: DONE held 10 cycles, requester 1 waits for release
      @(posedge CLK);
      #1;
      RSP_READY = 1'b0;
      issue(0, 3'b000, 32'd3, 32'd4, 5'd0, 32'd7, 1);
      issue(1, 3'b000, 32'd1, 32'd2, 5'd0, 32'd3, 1);
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge CLK);
         if (RSP_VALID) got = 1'b1;
      end
      if (!got) fail("bp_timeout", "no response while stalled");
      for (int k = 0; k < 10; k++) begin
         if (k != 0) @(negedge CLK);
         chk($sformatf("bp_req_ready%0d", k), 64'(REQ_READY), 64'(0));
         chk($sformatf("bp_rsp_id%0d", k), 64'(RSP_ID), 64'(0));
      end
      @(posedge CLK);
      #1;
      RSP_READY = 1'b1;
      rel_cyc = cyc;
      wait_drain();
      chk("bp_grant_after_release", 64'(hs_cyc), 64'(rel_cyc + 1));

      // Reset in the 2nd of 6 EXEC cycles of a shift from requester 0
      start = hs_count;
      issue(0, 3'b010, 32'h3, 32'h0, 5'd6, 32'hC0, 6);
      wait_hs(start);
      @(negedge CLK);
      chk("mid_exec1_a", 64'(ALU_A), 64'(3));
      @(posedge CLK);
      #1;
      RST = 1'b1;
      sb.delete();
      @(negedge CLK);
      chk("mid_exec2_a", 64'(ALU_A), 64'(6));
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("mid_rst_busy", 64'(BUSY), 64'(0));
      chk("mid_rst_rsp_valid", 64'(RSP_VALID), 64'(0));
      chk("mid_rst_alu_a", 64'(ALU_A), 64'(0));
      repeat (8) @(posedge CLK);
      issue(0, 3'b000, 32'd100, 32'd1, 5'd0, 32'd101, 1);
      issue(1, 3'b001, 32'd100, 32'd1, 5'd0, 32'd99, 1);
      wait_drain();

      repeat (3) @(posedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
